// File: rtl/calc1_port_arbiter_if.sv
// Request/response bundle between NREQ requesters, the calc1 port arbiter and one calc1 port group.
// Latency: none (wires only).
// Backpressure: req_valid is held until the matching one-hot req_ready pulse; responses are strobed with no stall.
//
// Port summary:
//   requester side : req_valid, req_cmd, req_op1, req_op2 -> arbiter; req_ready, resp_* <- arbiter
//   calc1 side     : calc_cmd, calc_data -> calc1; calc_resp, calc_out <- calc1
//   status         : busy
interface calc1_port_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [4*NREQ-1:0]    req_cmd;
    logic [32*NREQ-1:0]   req_op1;
    logic [32*NREQ-1:0]   req_op2;
    logic [NREQ-1:0]      req_ready;

    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic [1:0]           resp_code;
    logic [31:0]          resp_data;

    logic [3:0]           calc_cmd;
    logic [31:0]          calc_data;
    logic [1:0]           calc_resp;
    logic [31:0]          calc_out;

    logic                 busy;

    // Arbiter view.
    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_out,
        output req_ready, resp_valid, resp_id, resp_code, resp_data,
               calc_cmd, calc_data, busy
    );

    // Requesters plus calc1 view.
    modport master (
        output req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_out,
        input  req_ready, resp_valid, resp_id, resp_code, resp_data,
               calc_cmd, calc_data, busy
    );
endinterface

// File: rtl/calc1_port_arbiter.sv
// Round-robin share of one calc1 port among NREQ requesters; serialises cmd+op1 then op2, returns tagged response.
// Latency: req_ready 1 cycle after acceptance edge; resp_valid 1 cycle after calc1 responds (NOP: same cycle as req_ready).
// Backpressure: one request in flight; req_valid is ignored while busy and simply waits for the next IDLE visit.
//
// Ports: c_clk, reset (async active-low), bus (calc1_port_arbiter_if.slave: requester, response and calc1 signals).
// Optional feature: define CALC1_ARB_TIMEOUT_EN to end a WAIT that lasts TIMEOUT cycles with code 3.
module calc1_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   c_clk,
    input  logic                   reset,
    calc1_port_arbiter_if.slave    bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND1,
        S_SEND2,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDW-1:0]     last;
    logic [IDW-1:0]     id_q;
    logic [31:0]        op2_q;

    logic [NREQ-1:0]    req_ready_q;
    logic               resp_valid_q;
    logic [IDW-1:0]     resp_id_q;
    logic [1:0]         resp_code_q;
    logic [31:0]        resp_data_q;
    logic [3:0]         calc_cmd_q;
    logic [31:0]        calc_data_q;
    logic               busy_q;

    // Grant selection.
    logic               gnt_vld;
    logic [IDW-1:0]     gnt_idx;
    logic [NREQ-1:0]    gnt_oh;
    logic [IDW:0]       cand;
    logic [3:0]         gnt_cmd;
    logic [31:0]        gnt_op1;
    logic [31:0]        gnt_op2;

`ifdef CALC1_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]      wait_cnt;
`else
    // TIMEOUT only matters when the timeout logic is compiled in; referencing it
    // here keeps the parameter visible in both builds.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Scan from last+1 upward, wrapping at NREQ; NREQ need not be a power of two,
    // so the wrap is an explicit compare-and-subtract on a one-bit-wider index.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, last} + (IDW+1)'(i + 1);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_vld && bus.req_valid[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end

        gnt_oh  = '0;
        gnt_cmd = '0;
        gnt_op1 = '0;
        gnt_op2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                gnt_oh[k] = gnt_vld;
                gnt_cmd   = bus.req_cmd[4*k +: 4];
                gnt_op1   = bus.req_op1[32*k +: 32];
                gnt_op2   = bus.req_op2[32*k +: 32];
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            last         <= IDW'(NREQ - 1);
            id_q         <= '0;
            op2_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_code_q  <= '0;
            resp_data_q  <= '0;
            calc_cmd_q   <= '0;
            calc_data_q  <= '0;
            busy_q       <= 1'b0;
`ifdef CALC1_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            // Both strobes are single-cycle pulses unless a state re-raises them.
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        req_ready_q <= gnt_oh;
                        last        <= gnt_idx;
                        id_q        <= gnt_idx;
                        op2_q       <= gnt_op2;
                        busy_q      <= 1'b1;
                        if (gnt_cmd == 4'd0) begin
                            // NOP completes locally; calc1 never sees it.
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= gnt_idx;
                            resp_code_q  <= 2'd0;
                            resp_data_q  <= '0;
                            state        <= S_DONE;
                        end else begin
                            calc_cmd_q  <= gnt_cmd;
                            calc_data_q <= gnt_op1;
                            state       <= S_SEND1;
                        end
                    end
                end

                S_SEND1: begin
                    calc_cmd_q  <= '0;
                    calc_data_q <= op2_q;
                    state       <= S_SEND2;
                end

                S_SEND2: begin
                    calc_data_q <= '0;
`ifdef CALC1_ARB_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    // A response in the limit cycle takes precedence over the timeout.
                    if (bus.calc_resp != 2'd0) begin
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_code_q  <= bus.calc_resp;
                        resp_data_q  <= bus.calc_out;
                        state        <= S_DONE;
                    end
`ifdef CALC1_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_code_q  <= 2'd3;
                        resp_data_q  <= '0;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_code  = resp_code_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.calc_cmd   = calc_cmd_q;
    assign bus.calc_data  = calc_data_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/calc1_port_arbiter.md
# calc1_port_arbiter

- Shares one calc1 request port between `NREQ` independent requesters.
- Each requester submits a complete two-operand command. The block arbitrates round-robin and serialises the command onto the calc1 port in calc1's two-cycle format: cmd + operand 1, then operand 2.
- It waits for the calc1 response and returns the response code and data to the winning requester, tagged with the requester's ID.
- It sits between the requesters and one calc1 `reqN_cmd_in`/`reqN_data_in`/`out_respN`/`out_dataN` port group.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT`, default 64: WAIT-state cycle limit. Used only when the timeout feature is compiled in (see Configuration).
- `c_clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid` in `NREQ`: per-requester request pending.
- `req_cmd` in 4·`NREQ`: per-requester command, using calc1 encoding.
- `req_op1` in 32·`NREQ`: per-requester operand 1.
- `req_op2` in 32·`NREQ`: per-requester operand 2.
- `req_ready` out `NREQ`: one-hot, one-cycle acceptance pulse.
- `resp_valid` out 1: response strobe, one cycle.
- `resp_id` out clog2(`NREQ`): index of the requester the response belongs to.
- `resp_code` out 2: 0 none, 1 success, 2 invalid/overflow, 3 internal error/timeout.
- `resp_data` out 32: result data.
- `calc_cmd` out 4: to calc1 `reqN_cmd_in`.
- `calc_data` out 32: to calc1 `reqN_data_in`.
- `calc_resp` in 2: from calc1 `out_respN`.
- `calc_out` in 32: from calc1 `out_dataN`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SEND1, SEND2, WAIT, DONE.
- **IDLE**
  - If any `req_valid` is high, grant the first requester at or after `last+1` (mod `NREQ`).
  - Pulse that requester's `req_ready` and capture its cmd, op1, op2 and ID.
  - Set `last` to the granted index.
  - Go to SEND1, or to DONE if the captured cmd is 0.
- **SEND1**
  - Drive `calc_cmd` = captured cmd and `calc_data` = op1.
  - Go to SEND2.
- **SEND2**
  - Drive `calc_cmd` = 0 and `calc_data` = op2.
  - Go to WAIT.
- **WAIT**
  - Drive `calc_cmd` = 0 and `calc_data` = 0.
  - On the first cycle with `calc_resp` ≠ 0, capture `calc_resp` and `calc_out`, then go to DONE.
- **DONE**
  - Drive `resp_valid` = 1 with the captured `resp_id`, `resp_code` and `resp_data`.
  - Go to IDLE.
- **Local NOP completion:** a NOP request (cmd 0) never touches calc1. It completes in DONE with code 0 and data 0.
- **Command validation:** the block does not validate commands; unsupported codes are forwarded and calc1 returns code 2.
- **Requester contract:** a requester holds `req_valid` and its operands stable until it sees `req_ready`. Operands are not sampled after the `req_ready` cycle.
- **Outstanding requests:** only one request is in flight at a time. `req_valid` inputs seen outside IDLE are ignored; no `req_ready` is issued.
- **Reset values:**
  - State IDLE; `last` = `NREQ`-1, so requester 0 has first priority.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_id`, `resp_code`, `resp_data`, `calc_cmd`, `calc_data`, `busy`.
  - Captured registers are 0.
- **Reset mid-operation:** the in-flight request is dropped and no response is issued. calc1's own reset is driven separately; this block does not drive it.

## Timing
- `req_ready` is a registered pulse in cycle T+1, where T is the edge that samples `req_valid` in IDLE.
- Relative to that acceptance edge T:
  - SEND1 cmd appears on `calc_cmd` at T+1.
  - op2 appears on `calc_data` at T+2.
  - WAIT begins at T+3.
- If calc1 presents a response on edge R, `resp_valid` is high for the cycle after R. The block is back in IDLE one cycle later.
- Minimum back-to-back acceptance spacing is 4 cycles plus calc1 latency.
- NOP request: `resp_valid` one cycle after acceptance.
- Simultaneous requests: exactly one grant per IDLE visit, in strict round-robin. A continuously requesting set is served 0,1,2,3,0,…
- A response arriving in SEND1 or SEND2 is a protocol error. It is ignored, and only WAIT samples `calc_resp`.

## Configuration
- **`CALC1_ARB_TIMEOUT_EN` defined:**
  - A WAIT-cycle counter, 0..`TIMEOUT`-1, is cleared on entry to WAIT.
  - If `TIMEOUT` cycles elapse with `calc_resp` = 0, go to DONE with code 3 and data 0.
  - A response arriving in the same cycle the limit is reached wins over the timeout.
- **`CALC1_ARB_TIMEOUT_EN` undefined:**
  - WAIT persists until a response arrives.
  - No counter logic is present.

## Test plan
- Requester 0: ADD, 255, 1 → `calc_cmd` = 1 / `calc_data` = 255, then `calc_data` = 1; `resp_id` 0, code 1, data 256.
- Requesters 1 and 2 both assert SUB, 5, 3 in the same cycle after reset → 1 is served first, then 2; both respond with code 1, data 2.
- All four requesters hold `req_valid` for 8 grants → grant order is 0,1,2,3,0,1,2,3.
- Requester 3: ADD, 0xFFFFFFFF, 1 → `resp_id` 3, code 2; `req_cmd` = 0 from requester 1 → code 0 one cycle after acceptance, `calc_cmd` stays 0.
- `reset` asserted in WAIT → all outputs 0 immediately, with no `resp_valid`; after release, requester 0 has priority.
- With `CALC1_ARB_TIMEOUT_EN` and `TIMEOUT` = 8, calc1 held with no response → code 3, data 0, 8 cycles after entering WAIT.
